// File: rtl/icache_pkg.sv
// Shared fetch-side types and cache geometry for the direct-mapped instruction cache.
package icache_pkg;
  localparam int REG_WIDTH = 32;
  typedef logic [31:0]          pc_t;
  typedef logic [REG_WIDTH-1:0] reg_t;

  localparam int ICACHE_SETS       = 64;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int FETCH_WIDTH       = 4;

  localparam int ICACHE_OFF_W = $clog2(ICACHE_LINE_WORDS);
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 32 - ICACHE_OFF_W - ICACHE_IDX_W - 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_REFILL,
    ST_REPLAY
  } icache_state_e;
endpackage

// File: rtl/icache_tag_array.sv
// Per-set valid bits (reset) and tags (not reset); a flush clears every valid and wins over a write.
module icache_tag_array #(
  parameter int SETS  = 64,
  parameter int TAG_W = 22
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(SETS)-1:0] rd_idx_i,
  output logic                    rd_valid_o,
  output logic [TAG_W-1:0]        rd_tag_o,
  input  logic                    wr_en_i,
  input  logic [$clog2(SETS)-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]        wr_tag_i,
  input  logic                    wr_valid_i,
  input  logic                    flush_i
);
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) tag_q[wr_idx_i] <= wr_tag_i;
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: 1-cycle hit lookup, burst line refill on miss, kill and flush.
// Handshakes: a transfer happens on a cycle where valid && ready; a valid source holds its payload until then.
module icache_dm import icache_pkg::*; #(
  parameter int SETS        = ICACHE_SETS,
  parameter int LINE_WORDS  = ICACHE_LINE_WORDS,
  parameter int FETCH_WIDTH = icache_pkg::FETCH_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  input  pc_t                                   req_pc,
  output logic                                  req_ready,
  input  logic                                  kill,
  input  logic                                  flush,
  output logic                                  resp_valid,
  output logic [FETCH_WIDTH-1:0][REG_WIDTH-1:0] resp_inst,
  output logic [FETCH_WIDTH-1:0]                resp_mask,
  output logic                                  mem_req_valid,
  output pc_t                                   mem_req_addr,
  input  logic                                  mem_req_ready,
  input  logic                                  mem_rvalid,
  input  reg_t                                  mem_rdata,
  input  logic                                  mem_rlast,
  output icache_state_e                         dbg_state_o
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - OFF_W - IDX_W - 2;

  icache_state_e    state_q, state_d;
  pc_t              pc_q, pc_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic             killed_q, killed_d;
  logic             fpend_q, fpend_d;
  reg_t             data_q [SETS][LINE_WORDS];

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag, rd_tag;
  logic             rd_valid, hit, refill_beat, refill_last;
  logic             ready, rvalid, mreq;
  logic [FETCH_WIDTH-1:0][REG_WIDTH-1:0] grp_inst;
  logic [FETCH_WIDTH-1:0]                grp_mask;

  assign pc_off      = pc_q[2 +: OFF_W];
  assign pc_idx      = pc_q[2 + OFF_W +: IDX_W];
  assign pc_tag      = pc_q[31 -: TAG_W];
  assign hit         = rd_valid && (rd_tag == pc_tag);
  assign refill_beat = (state_q == ST_REFILL) && mem_rvalid;
  assign refill_last = refill_beat && mem_rlast;

  // A refill overlapped by a flush still installs its tag, but never as valid.
  icache_tag_array #(.SETS(SETS), .TAG_W(TAG_W)) u_tags (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (pc_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .wr_en_i    (refill_last),
    .wr_idx_i   (pc_idx),
    .wr_tag_i   (pc_tag),
    .wr_valid_i (!(fpend_q || flush)),
    .flush_i    (flush)
  );

  always_ff @(posedge clk) begin
    if (refill_beat) data_q[pc_idx][beat_q] <= mem_rdata;
  end

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      grp_inst[i] = data_q[pc_idx][OFF_W'((int'(pc_off) / FETCH_WIDTH) * FETCH_WIDTH + i)];
      grp_mask[i] = (i >= int'(pc_off) % FETCH_WIDTH);
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    beat_d   = beat_q;
    killed_d = killed_q;
    fpend_d  = fpend_q;
    ready    = 1'b0;
    rvalid   = 1'b0;
    mreq     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (req_valid) begin
          pc_d    = req_pc;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          rvalid = 1'b1;
          ready  = 1'b1;
          if (req_valid) begin
            pc_d    = req_pc;
            state_d = ST_LOOKUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        mreq = 1'b1;
        if (mem_req_ready) begin
          beat_d  = '0;
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (mem_rvalid) begin
          beat_d = beat_q + OFF_W'(1);
          if (mem_rlast) state_d = ST_REPLAY;
        end
      end
      ST_REPLAY: begin
        rvalid  = !killed_q && !kill;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (kill && (state_q == ST_MISS_REQ || state_q == ST_REFILL)) killed_d = 1'b1;
    if (flush && (state_q == ST_MISS_REQ || state_q == ST_REFILL ||
                  (state_q == ST_LOOKUP && !hit && !kill))) fpend_d = 1'b1;
    if (state_d == ST_IDLE) begin
      killed_d = 1'b0;
      fpend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      beat_q   <= '0;
      killed_q <= 1'b0;
      fpend_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      beat_q   <= beat_d;
      killed_q <= killed_d;
      fpend_q  <= fpend_d;
    end
  end

  // The memory side must deliver exactly LINE_WORDS beats, marking only the last.
  always_ff @(posedge clk) begin
    if (rst_n && refill_beat) assert (mem_rlast == (beat_q == OFF_W'(LINE_WORDS - 1)));
  end

  assign req_ready     = ready && rst_n;
  assign resp_valid    = rvalid;
  assign resp_inst     = rvalid ? grp_inst : '0;
  assign resp_mask     = rvalid ? grp_mask : '0;
  assign mem_req_valid = mreq;
  assign mem_req_addr  = mreq ? {pc_q[31:OFF_W+2], {(OFF_W+2){1'b0}}} : '0;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_icache_dm.sv
// Directed plus randomized fetch sequences against a line-level cache model and a lazily filled memory.
module tb_icache_dm;
  import icache_pkg::*;

  localparam int SETS = 64;
  localparam int LW   = 4;
  localparam int FW   = 4;
  localparam int OFFB = $clog2(LW);
  localparam int W    = FW * 32 + FW;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 req_valid, kill, flush;
  logic [31:0]          req_pc;
  logic                 req_ready, resp_valid;
  logic [FW-1:0][31:0]  resp_inst;
  logic [FW-1:0]        resp_mask;
  logic                 mem_req_valid, mem_req_ready, mem_rvalid, mem_rlast;
  logic [31:0]          mem_req_addr, mem_rdata;
  icache_state_e        dbg_state;

  icache_dm #(.SETS(SETS), .LINE_WORDS(LW), .FETCH_WIDTH(FW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_pc        (req_pc),
    .req_ready     (req_ready),
    .kill          (kill),
    .flush         (flush),
    .resp_valid    (resp_valid),
    .resp_inst     (resp_inst),
    .resp_mask     (resp_mask),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .mem_rlast     (mem_rlast),
    .dbg_state_o   (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: which memory line each set holds, and the backing memory words.
  logic          ref_valid [SETS];
  logic [31:0]   ref_line  [SETS];
  logic [31:0]   mem_m [logic [31:0]];
  logic [W-1:0]  exp_q [$];
  int            checks = 0;
  int            passes = 0;
  int            fails  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem_m.exists(a)) mem_m[a] = $urandom;
    return mem_m[a];
  endfunction

  function automatic logic [W-1:0] model_resp(input logic [31:0] pc);
    logic [FW-1:0][31:0] inst;
    logic [FW-1:0]       mask;
    int                  off, grp;
    off = int'(pc[2 +: OFFB]);
    grp = (off / FW) * FW;
    for (int i = 0; i < FW; i++) begin
      inst[i] = mem_word((pc & ~32'(LW * 4 - 1)) + 32'(4 * (grp + i)));
      mask[i] = (i >= off % FW);
    end
    return {mask, inst};
  endfunction

  function automatic int set_of(input logic [31:0] pc);
    return int'((pc >> (OFFB + 2)) % SETS);
  endfunction

  function automatic logic model_hit(input logic [31:0] pc);
    return ref_valid[set_of(pc)] && ref_line[set_of(pc)] == (pc >> (OFFB + 2));
  endfunction

  task automatic clear_model();
    for (int s = 0; s < SETS; s++) ref_valid[s] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_resp(input string tag);
    chk({tag, "_valid"}, W'(resp_valid), W'(1));
    chk(tag, {resp_mask, resp_inst}, exp_q.pop_front());
  endtask

  // kill_ph: 0 none, 1 in lookup, 2 in miss request, 3 on refill beat kb.
  // flush_ph: 0 none, 1 in a hit lookup, 3 on refill beat fb.
  task automatic fetch(input logic [31:0] pc, input int kill_ph, input int kb,
                       input int flush_ph, input int fb);
    logic hit;
    int   idx;
    hit = model_hit(pc);
    idx = set_of(pc);
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = pc;
    chk("idle_ready", W'(req_ready), W'(1));
    @(negedge clk);
    req_valid = 1'b0;
    if (kill_ph == 1) begin
      kill = 1'b1;
      #1;
      chk("kill_lookup_resp", W'(resp_valid), W'(0));
      chk("kill_lookup_ready", W'(req_ready), W'(0));
      @(negedge clk);
      kill = 1'b0;
      chk("kill_back_idle", W'(req_ready), W'(1));
      return;
    end
    if (hit) begin
      exp_q.push_back(model_resp(pc));
      if (flush_ph == 1) flush = 1'b1;
      #1;
      expect_resp("hit");
      @(negedge clk);
      flush = 1'b0;
      if (flush_ph == 1) clear_model();
      chk("hit_single_cycle", W'(resp_valid), W'(0));
      return;
    end
    chk("miss_resp", W'(resp_valid), W'(0));
    chk("miss_ready", W'(req_ready), W'(0));
    @(negedge clk);
    if (kill_ph == 2) kill = 1'b1;
    repeat ($urandom_range(0, 2)) begin
      chk("mreq_hold_valid", W'(mem_req_valid), W'(1));
      chk("mreq_hold_addr", W'(mem_req_addr), W'(pc & ~32'(LW * 4 - 1)));
      @(negedge clk);
      kill = 1'b0;
    end
    chk("mreq_valid", W'(mem_req_valid), W'(1));
    chk("mreq_addr", W'(mem_req_addr), W'(pc & ~32'(LW * 4 - 1)));
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    kill          = 1'b0;
    for (int b = 0; b < LW; b++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word((pc & ~32'(LW * 4 - 1)) + 32'(4 * b));
      mem_rlast  = (b == LW - 1);
      kill       = (kill_ph == 3 && b == kb);
      flush      = (flush_ph == 3 && b == fb);
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rlast  = 1'b0;
      kill       = 1'b0;
      flush      = 1'b0;
    end
    if (flush_ph == 3) clear_model();
    ref_line[idx]  = pc >> (OFFB + 2);
    ref_valid[idx] = (flush_ph != 3);
    if (kill_ph == 2 || kill_ph == 3) begin
      chk("killed_replay", W'(resp_valid), W'(0));
    end else begin
      exp_q.push_back(model_resp(pc));
      expect_resp("replay");
    end
    @(negedge clk);
    chk("post_replay_resp", W'(resp_valid), W'(0));
    chk("post_replay_ready", W'(req_ready), W'(1));
  endtask

  task automatic back_to_back(input logic [31:0] pc0, input logic [31:0] pc1);
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = pc0;
    @(negedge clk);
    exp_q.push_back(model_resp(pc0));
    expect_resp("b2b_first");
    chk("b2b_ready", W'(req_ready), W'(1));
    req_pc = pc1;
    @(negedge clk);
    req_valid = 1'b0;
    exp_q.push_back(model_resp(pc1));
    expect_resp("b2b_second");
    @(negedge clk);
    chk("b2b_end", W'(resp_valid), W'(0));
  endtask

  initial begin
    int r, kp, fp;
    rst_n = 1'b0; req_valid = 1'b0; req_pc = '0; kill = 1'b0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
    clear_model();
    mem_m[32'h0] = 32'h34010001;
    mem_m[32'h4] = 32'h34020001;
    mem_m[32'h8] = 32'h34030000;
    mem_m[32'hC] = 32'h24040000;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", W'(req_ready), W'(0));
    chk("rst_resp_valid", W'(resp_valid), W'(0));
    chk("rst_mem_req", W'({mem_req_valid, mem_req_addr}), W'(0));
    chk("rst_resp_bus", W'({resp_mask, resp_inst}), W'(0));
    rst_n = 1'b1;

    fetch(32'h0, 0, 0, 0, 0);
    fetch(32'h8, 0, 0, 0, 0);
    back_to_back(32'h0, 32'h4);
    fetch(32'h400, 0, 0, 0, 0);
    fetch(32'h0, 0, 0, 0, 0);
    fetch(32'h40, 3, 2, 0, 0);
    fetch(32'h40, 0, 0, 0, 0);
    fetch(32'h80, 0, 0, 3, 1);
    fetch(32'h80, 0, 0, 0, 0);
    fetch(32'h0, 0, 0, 0, 0);
    fetch(32'h84, 1, 0, 0, 0);
    fetch(32'h44, 2, 0, 0, 0);
    fetch(32'h88, 0, 0, 1, 0);
    fetch(32'h80, 0, 0, 0, 0);
    fetch(32'hC0, 0, 0, 3, 3);
    fetch(32'hC4, 0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      r  = int'($urandom_range(0, 7));
      kp = (r < 4) ? 0 : r - 4;
      r  = int'($urandom_range(0, 7));
      fp = (r == 0) ? 3 : (r == 1) ? 1 : 0;
      fetch(32'($urandom_range(0, 1) << 10) | 32'($urandom_range(0, 3) << 4) |
            32'($urandom_range(0, 3) << 2), kp, int'($urandom_range(0, 3)),
            fp, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a refill drops everything back to idle with no valid lines.
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = 32'h100;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b1;
    mem_rdata     = mem_word(32'h100);
    @(negedge clk);
    mem_rvalid = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("midrst_state", W'(dbg_state), W'(ST_IDLE));
    chk("midrst_outputs", W'({req_ready, resp_valid, mem_req_valid}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    fetch(32'h100, 0, 0, 0, 0);
    fetch(32'h104, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Parametrised direct-mapped instruction cache. Replaces the fixed combinational instruction ROM in the fetch stage.
- Returns an aligned group of up to FETCH_WIDTH instructions per request.
- On a miss, refills one line from the memory side over a burst handshake.
- Supports branch-redirect kill and a full-cache flush (for the cache instruction / fence).

Parameters:
- SETS, 64, number of lines; power of two, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least FETCH_WIDTH.
- FETCH_WIDTH, 4, instructions returned per response; power of two.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  fetch request
- req_pc  in  32  fetch PC (PC type)
- req_ready  out  1  request accepted when req_valid && req_ready
- kill  in  1  cancel the outstanding request (redirect)
- flush  in  1  invalidate all lines
- resp_valid  out  1  response valid, single cycle, no backpressure
- resp_inst  out  FETCH_WIDTH x 32  instruction group (REG_WIDTH array)
- resp_mask  out  FETCH_WIDTH  bit i set if word i is at or after the PC
- mem_req_valid  out  1  refill request
- mem_req_addr  out  32  line-aligned refill address
- mem_req_ready  in  1  refill request accepted
- mem_rvalid  in  1  refill data beat
- mem_rdata  in  32  beat data, ascending word order
- mem_rlast  in  1  last beat of the line

Behaviour:
- Address split:
  - [1:0] ignored.
  - word offset = next log2(LINE_WORDS) bits.
  - index = next log2(SETS) bits.
  - tag = remaining upper bits.
- Fetch group:
  - words g*FETCH_WIDTH .. g*FETCH_WIDTH+FETCH_WIDTH-1 of the line, where g = word offset / FETCH_WIDTH.
  - resp_mask[i] = (i >= word offset mod FETCH_WIDTH).
- Storage: valid bit per set plus tag and data arrays, all registers. On reset, all valid bits = 0; data and tag arrays are not reset.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, REPLAY.
- IDLE:
  - req_ready=1.
  - On acceptance, latch the PC and go to LOOKUP.
- LOOKUP (cycle after acceptance):
  - hit = valid[index] && tag match.
  - Hit: resp_valid=1 with data from the arrays. req_ready=1 this cycle, so hit-to-hit requests pipeline back-to-back with 1-cycle latency. Next state is LOOKUP on a new acceptance, else IDLE.
  - Miss: req_ready=0, go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid=1, mem_req_addr = PC with word and byte offsets zeroed.
  - mem_req_valid and mem_req_addr are held stable until mem_req_ready, then go to REFILL.
- REFILL:
  - Each mem_rvalid writes mem_rdata to the beat counter's word, then the counter increments.
  - On the mem_rlast beat, write tag, set valid, go to REPLAY.
  - Exactly LINE_WORDS beats are expected. mem_rlast on any other beat is an assertion error.
- REPLAY: resp_valid=1 from the refilled line (1 cycle), then IDLE.
- Miss latency: 1 (lookup) + 1 (request, if ready immediately) + LINE_WORDS beats + 1 (replay).
- kill:
  - In LOOKUP: suppresses resp_valid; the state returns to IDLE and no new request is accepted that cycle.
  - In MISS_REQ: the memory request still completes its handshake (no retraction).
  - In MISS_REQ or REFILL: the refill completes and the line is installed, but REPLAY emits no response.
  - kill with no request outstanding is ignored.
- flush:
  - Clears all valid bits next cycle.
  - If a refill is in progress, the line is still written but its valid is not set (a pending-flush bit is cleared on return to IDLE).
  - flush and the mem_rlast write in the same cycle: flush wins.
  - A hit lookup in the flush cycle still responds, since the arrays are read before the clear.
- Reset mid-refill:
  - All state returns to IDLE and all valids clear.
  - The memory side must be reset together with this block.
- All outputs are 0 during reset.

Decomposition:
- Shared package, alongside the existing PC and REG_WIDTH types:
  - ICACHE_SETS, ICACHE_LINE_WORDS, FETCH_WIDTH constants.
  - icache_state_e enum.
  - derived widths for offset, index and tag.
- One sub-module, icache_tag_array: valid and tag registers, read port, write port, flush-clear port.

Test Plan:
- Reset, then request 0x00000000: miss, mem_req_addr=0x0, 4 beats 0x34010001, 0x34020001, 0x34030000, 0x24040000 -> REPLAY resp_inst equals those words, resp_mask=4'b1111.
- Request 0x00000008 right after -> hit, resp_valid exactly 1 cycle after acceptance, resp_mask=4'b1100, same resp_inst.
- Back-to-back hits at 0x0 and 0x4 on consecutive cycles -> two consecutive resp_valid cycles, masks 1111 then 1110.
- Request 0x00000400 (same index as 0x0, different tag) -> miss, refill evicts; request 0x0 again -> miss.
- Miss at 0x40 with kill asserted during beat 2 -> no resp_valid; later request 0x40 -> hit with the refilled data.
- flush asserted during a refill at 0x80 -> no valid set; request 0x80 -> miss; request 0x0 (previously valid) -> miss.
